// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor computing (a - b) mod 2^WIDTH
// over WIDTH cycles, LSB first, with a single one-bit subtract cell and a
// registered borrow. start/busy/done handshake; results held until next DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  // Counter only ever needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             br_nxt;
  logic             x;
  logic             last_bit;

  // One-bit subtract cell: difference output.
  function automatic logic diff_bit(input logic ai, input logic bi, input logic bin);
    return ai ^ bi ^ bin;
  endfunction

  // One-bit subtract cell: borrow output.
  function automatic logic borrow_bit(input logic ai, input logic bi, input logic bin);
    return (~ai & bi) | (~(ai ^ bi) & bin);
  endfunction

  // Subtract cell and accumulator shift: new bit enters at the MSB.
  always_comb begin
    x        = diff_bit(sa[0], sb[0], br);
    br_nxt   = borrow_bit(sa[0], sb[0], br);
    acc_nxt  = acc >> 1;
    acc_nxt[WIDTH-1] = x;
    last_bit = (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Operand capture, bit-serial datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      d    <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
            acc <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          acc <= acc_nxt;
          if (last_bit) begin
            d    <= acc_nxt;
            bout <= br_nxt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed table vectors and hand-written sequences on a
// WIDTH=8 instance, plus an exhaustive sweep of a WIDTH=4 instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8;
  logic [7:0] a8, b8, d8;
  logic       bout8, busy8, done8;
  logic       start4;
  logic [3:0] a4, b4, d4;
  logic       bout4, busy4, done4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .d(d8), .bout(bout8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .d(d4), .bout(bout4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bout;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one WIDTH=8 operation from IDLE; returns result, done latency and busy count.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v,
                     output logic [7:0] rd, output logic rb,
                     output int lat, output int bcnt, output logic seen);
    @(negedge clk);
    a8 = ta; b8 = tb_v; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0; bcnt = 0; seen = 1'b0;
    while (lat < 30 && !seen) begin
      @(negedge clk);
      lat++;
      if (busy8) bcnt++;
      if (busy8 && done8) check("busy_and_done", 1, 0);
      if (done8) seen = 1'b1;
    end
    rd = d8; rb = bout8;
  endtask

  // Same for the WIDTH=4 instance.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v,
                     output logic [3:0] rd, output logic rb, output logic seen);
    int lat;
    @(negedge clk);
    a4 = ta; b4 = tb_v; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    lat = 0; seen = 1'b0;
    while (lat < 20 && !seen) begin
      @(negedge clk);
      lat++;
      if (done4) seen = 1'b1;
    end
    rd = d4; rb = bout4;
  endtask

  initial begin
    logic [7:0] rd;
    logic       rb;
    logic [3:0] rd4;
    logic       rb4;
    logic       seen;
    int         lat, bcnt;
    int         ndone, busy_after;
    int         t_done[3];

    vecs[0] = '{a: 8'h5A, b: 8'h23, d: 8'h37, bout: 1'b0};
    vecs[1] = '{a: 8'h10, b: 8'h20, d: 8'hF0, bout: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'hFF, d: 8'h01, bout: 1'b1};
    vecs[3] = '{a: 8'hA5, b: 8'hA5, d: 8'h00, bout: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, bout: 1'b0};

    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    check("reset_d", d8, 0);
    check("reset_bout", bout8, 0);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      op8(vecs[i].a, vecs[i].b, rd, rb, lat, bcnt, seen);
      check($sformatf("vec%0d_seen", i), seen, 1);
      check($sformatf("vec%0d_d", i), rd, vecs[i].d);
      check($sformatf("vec%0d_bout", i), rb, vecs[i].bout);
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
    end

    // Operand isolation and start while busy
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    ndone = 0; busy_after = 0; rd = '0; rb = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (ndone > 0 && busy8) busy_after++;
      if (done8) begin
        ndone++;
        rd = d8; rb = bout8;
      end
      if (i == 4) begin a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1; end
      if (i == 5) start8 = 1'b0;
    end
    check("iso_done_count", ndone, 1);
    check("iso_d", rd, 8'h7F);
    check("iso_bout", rb, 0);
    check("iso_no_second_op", busy_after, 0);

    // Held start
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 40 && ndone < 3; i++) begin
      @(negedge clk);
      if (done8) begin
        t_done[ndone] = i;
        ndone++;
        check("held_d", d8, 8'hFE);
        check("held_bout", bout8, 1);
      end
    end
    start8 = 1'b0;
    check("held_done_count", ndone, 3);
    if (ndone == 3) begin
      check("held_spacing1", t_done[1] - t_done[0], 10);
      check("held_spacing2", t_done[2] - t_done[1], 10);
    end
    repeat (2) @(negedge clk);

    // Reset mid-operation (d currently holds 0xFE, bout 1)
    a8 = 8'h5A; b8 = 8'h23; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", busy8, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_d", d8, 0);
    check("rst_bout", bout8, 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("rst_no_done", ndone, 0);
    op8(8'h0C, 8'h04, rd, rb, lat, bcnt, seen);
    check("post_rst_seen", seen, 1);
    check("post_rst_d", rd, 8'h08);
    check("post_rst_bout", rb, 0);
    check("post_rst_latency", lat, 9);

    // Exhaustive WIDTH=4 sweep against a reference model
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        logic [3:0] ea, eb, ed;
        logic       eb_o;
        ea = 4'(ia); eb = 4'(ib);
        ed = 4'((ia - ib) & 15);
        eb_o = (ia < ib);
        op4(ea, eb, rd4, rb4, seen);
        check($sformatf("w4_seen_%0h_%0h", ia, ib), seen, 1);
        check($sformatf("w4_d_%0h_%0h", ia, ib), rd4, ed);
        check($sformatf("w4_bout_%0h_%0h", ia, ib), rb4, eb_o);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
